// File: rtl/calc_operand_sequencer.sv
// Purpose: debounces ENTER/CLEAR and sequences operand A, operand B and opcode capture for the calculator.
// Latency: a button press is acted on DEBOUNCE_CYCLES+2 edges after its first sampled-high edge.
// Backpressure: {a,b,op} and op_valid hold in S_ISSUE until op_ready; enter presses there are dropped.
module calc_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [1:0]       sw_op,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       op,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       phase,
    output logic [7:0]       issue_cnt
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is ENTER, bit 1 is CLEAR; both buttons share identical conditioning.
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         deb_q;
    logic [1:0][CW-1:0] deb_cnt;

    logic enter_evt;
    logic clear_evt;

    state_t state;
    state_t state_nxt;
    logic   cap_a;
    logic   cap_b;
    logic   cap_op;
    logic   do_clear;
    logic   handshake;

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_clear, btn_enter};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == CNT_MAX) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed debounced level for rising-edge event detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    assign enter_evt = deb[BTN_ENTER] & ~deb_q[BTN_ENTER];
    assign clear_evt = deb[BTN_CLEAR] & ~deb_q[BTN_CLEAR];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and capture strobes; clear overrides enter and the handshake.
    always_comb begin
        state_nxt = state;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_op    = 1'b0;
        do_clear  = 1'b0;
        handshake = 1'b0;
        if (clear_evt) begin
            do_clear  = 1'b1;
            state_nxt = S_A;
        end else begin
            case (state)
                S_A: begin
                    if (enter_evt) begin
                        cap_a     = 1'b1;
                        state_nxt = S_B;
                    end
                end
                S_B: begin
                    if (enter_evt) begin
                        cap_b     = 1'b1;
                        state_nxt = S_OP;
                    end
                end
                S_OP: begin
                    if (enter_evt) begin
                        cap_op    = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        handshake = 1'b1;
                        state_nxt = S_A;
                    end
                end
                default: state_nxt = S_A;
            endcase
        end
    end

    // Operand/opcode registers; values persist past the handshake until recaptured or cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a  <= '0;
            b  <= '0;
            op <= '0;
        end else if (do_clear) begin
            a  <= '0;
            b  <= '0;
            op <= '0;
        end else begin
            if (cap_a)  a  <= sw_data;
            if (cap_b)  b  <= sw_data;
            if (cap_op) op <= sw_op;
        end
    end

    // Handshake counter; wraps naturally at 8 bits and ignores clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (handshake) begin
            issue_cnt <= issue_cnt + 8'd1;
        end
    end

    assign op_valid = (state == S_ISSUE);
    assign phase    = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Purpose: directed self-checking bench for calc_operand_sequencer with DEBOUNCE_CYCLES=4.
// Latency: expects capture 6 edges after the first edge sampling a raw press.
// Backpressure: holds op_ready low to verify stable {a,b,op} while op_valid waits.
module tb_calc_operand_sequencer;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sw_data;
    logic [1:0]       sw_op;
    logic             btn_enter;
    logic             btn_clear;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       phase;
    logic [7:0]       issue_cnt;

    int        n_checks = 0;
    int        n_fail   = 0;
    logic [7:0] exp_cnt = 8'd0;

    calc_operand_sequencer #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_data  (sw_data),
        .sw_op    (sw_op),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .a        (a),
        .b        (b),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .phase    (phase),
        .issue_cnt(issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Raise ENTER just after an edge and return at the negedge following the capture edge.
    task automatic press_enter();
        @(posedge clk);
        #1 btn_enter = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
    endtask

    // Release ENTER and let the debounced level settle low before the next press.
    task automatic release_enter();
        btn_enter = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enter_value(input logic [WIDTH-1:0] v);
        sw_data = v;
        press_enter();
        release_enter();
    endtask

    // Full entry with ready high; handshake happens on the edge after op capture.
    task automatic full_issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                              input logic [1:0] vop);
        op_ready = 1'b1;
        enter_value(va);
        enter_value(vb);
        sw_op = vop;
        press_enter();
        release_enter();
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_data   = '0;
        sw_op     = '0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        op_ready  = 1'b0;
        #2;
        check("reset_phase", 16'(phase), 16'd0);
        check("reset_abop", {8'(a), 4'(b), 2'(op), 1'b0, op_valid}, 16'd0);
        check("reset_cnt", 16'(issue_cnt), 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Short glitch must be filtered.
        sw_data = 4'd9;
        @(posedge clk);
        #1 btn_enter = 1'b1;
        repeat (DEB - 1) @(posedge clk);
        #1 btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_phase", 16'(phase), 16'd0);
        check("glitch_a", 16'(a), 16'd0);

        // Clean press: nothing at E+5, capture exactly at E+6.
        sw_data = 4'd3;
        @(posedge clk);
        #1 btn_enter = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        check("pre_capture_phase", 16'(phase), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("capture_phase", 16'(phase), 16'd1);
        check("capture_a", 16'(a), 16'd3);
        // Held for 100 more cycles: still a single capture.
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("held_phase", 16'(phase), 16'd1);
        release_enter();

        // Basic issue with ready high: valid for exactly one cycle.
        enter_value(4'd5);
        check("b_capture", 16'(b), 16'd5);
        check("phase_op", 16'(phase), 16'd2);
        op_ready = 1'b1;
        sw_op    = 2'b00;
        press_enter();
        check("issue_valid", 16'(op_valid), 16'd1);
        check("issue_abop", {8'(a), 4'(b), 2'(op), 2'b00}, {8'd3, 4'd5, 2'd0, 2'b00});
        @(negedge clk);
        check("issue_drop", 16'(op_valid), 16'd0);
        check("issue_phase", 16'(phase), 16'd0);
        check("issue_cnt1", 16'(issue_cnt), 16'd1);
        exp_cnt = 8'd1;
        release_enter();

        // Backpressure: 20 cycles of held valid and stable operands.
        op_ready = 1'b0;
        enter_value(4'd9);
        enter_value(4'd12);
        sw_op = 2'b10;
        press_enter();
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {1'b0, op_valid, 8'(a), 4'(b), 2'(op)},
                  {1'b0, 1'b1, 8'd9, 4'd12, 2'd2});
            @(negedge clk);
        end
        op_ready = 1'b1;
        @(negedge clk);
        check("bp_drop", 16'(op_valid), 16'd0);
        check("bp_cnt", 16'(issue_cnt), 16'd2);
        check("bp_keep_a", 16'(a), 16'd9);
        exp_cnt = 8'd2;
        release_enter();

        // Enter ignored in S_ISSUE, then clear coinciding with a handshake.
        op_ready = 1'b0;
        enter_value(4'd7);
        enter_value(4'd1);
        sw_op = 2'b11;
        press_enter();
        release_enter();
        enter_value(4'd15);
        check("issue_ignore_phase", 16'(phase), 16'd3);
        check("issue_ignore_a", 16'(a), 16'd7);
        @(posedge clk);
        #1 btn_clear = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        check("pre_clear_phase", 16'(phase), 16'd3);
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("clear_phase", 16'(phase), 16'd0);
        check("clear_abop", {8'(a), 4'(b), 2'(op), 2'b00}, 16'd0);
        check("clear_cnt", 16'(issue_cnt), 16'd2);
        btn_clear = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        @(negedge clk);

        // Wrap: run issues until the counter rolls back to zero.
        while (exp_cnt != 8'd255) begin
            full_issue(4'(exp_cnt), ~4'(exp_cnt), exp_cnt[1:0]);
        end
        check("cnt_255", 16'(issue_cnt), 16'd255);
        full_issue(4'd11, 4'd4, 2'b01);
        check("cnt_wrap", 16'(issue_cnt), 16'd0);
        check("wrap_abop", {8'(a), 4'(b), 2'(op), 2'b00}, {8'd11, 4'd4, 2'd1, 2'b00});
        full_issue(4'd2, 4'd2, 2'b00);
        check("cnt_after_wrap", 16'(issue_cnt), 16'd1);

        // Asynchronous reset while in S_OP.
        op_ready = 1'b0;
        enter_value(4'd6);
        enter_value(4'd10);
        check("pre_reset_phase", 16'(phase), 16'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_phase", 16'(phase), 16'd0);
        check("async_rst_abop", {8'(a), 4'(b), 2'(op), 1'b0, op_valid}, 16'd0);
        check("async_rst_cnt", 16'(issue_cnt), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
